// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache fills
// and D-cache fills/write-backs. Every output is driven straight from a flop.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: D owned the most recent grant
  mem_req_t          req_q, req_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic i_req, d_req, grant_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  // On a tie, the side that did not win last time gets the port.
  assign grant_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    req_d     = req_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d    = D_BUSY;
          last_d_d   = 1'b1;
          req_d.addr = d_addr;
          // A simultaneous read+write from D is treated as a write.
          if (d_write) begin
            req_d.wr    = 1'b1;
            req_d.wdata = d_wdata;
          end else begin
            req_d.rd    = 1'b1;
          end
        end else if (i_req) begin
          state_d    = I_BUSY;
          last_d_d   = 1'b0;
          req_d.rd   = 1'b1;
          req_d.addr = i_addr;
        end
      end
      I_BUSY: begin
        if (mem_ready) begin
          state_d   = DONE;
          req_d.rd  = 1'b0;
          i_ready_d = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          state_d   = DONE;
          req_d.rd  = 1'b0;
          req_d.wr  = 1'b0;
          d_ready_d = 1'b1;
          if (req_q.rd) d_rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      req_q     <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      req_q     <= req_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_read  = req_q.rd;
  assign mem_write = req_q.wr;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued as requests
// are raised and retired when the matching cache ready pulse appears.
module tb_mem_arbiter;
  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int LAT = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Memory model: answers LAT cycles after a strobe rises, with the data the
  // scoreboard front expects; also fires stray ready pulses on request.
  bit            mem_auto = 1'b0;
  int            spur_cnt = 0, spur_done = 0;
  logic [DW-1:0] rd_data;

  initial begin
    forever begin
      @(negedge clk);
      if (spur_cnt != spur_done) begin
        spur_done++;
        mem_rdata = {4{32'hBAD0BAD0}};
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end else if (mem_auto && rst_n && (mem_read || mem_write)) begin
        repeat (LAT) @(negedge clk);
        rd_data   = (exp_q.size() > 0) ? exp_q[0].rdata : '0;
        mem_rdata = rd_data;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: checks each new memory strobe and each cache ready pulse.
  int   rise_cyc = 0, rdy_cyc = 0, last_gap = 0, i_cnt = 0, d_cnt = 0;
  logic prev_strb = 1'b0, prev_rdy = 1'b0, strb, rdy;
  exp_t em;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_strb = 1'b0;
        prev_rdy  = 1'b0;
      end else begin
        strb = mem_read | mem_write;
        rdy  = i_ready | d_ready;
        if (strb === 1'b1 && prev_strb === 1'b0) begin
          rise_cyc = cyc;
          last_gap = cyc - rdy_cyc;
          if (exp_q.size() == 0) chk("strobe_unexpected", 1'b1, 1'b0);
          else begin
            chk("mem_write_op", mem_write, exp_q[0].wr);
            chk("mem_read_op", mem_read, !exp_q[0].wr);
            chk("mem_addr", mem_addr, exp_q[0].addr);
            if (exp_q[0].wr) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
          end
        end
        if (rdy === 1'b1) begin
          chk("ready_one_cycle", prev_rdy, 1'b0);
          chk("ready_both", i_ready & d_ready, 1'b0);
          rdy_cyc = cyc;
          if (i_ready) i_cnt++;
          if (d_ready) d_cnt++;
          if (exp_q.size() == 0) chk("ready_unexpected", 1'b1, 1'b0);
          else begin
            em = exp_q.pop_front();
            chk("ready_owner_is_d", d_ready, em.is_d);
            if (!em.wr) chk("rdata", em.is_d ? d_rdata : i_rdata, em.rdata);
          end
        end
        prev_strb = strb;
        prev_rdy  = rdy;
      end
    end
  end

  task automatic wait_rdy(input bit is_d);
    bit hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      hit = is_d ? d_ready : i_ready;
    end
    chk(is_d ? "d_ready_seen" : "i_ready_seen", hit, 1'b1);
    #1;
  endtask

  task automatic wait_any(output bit who, output bit ok);
    ok = 1'b0; who = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin ok = 1'b1; who = d_ready; end
    end
    chk("any_ready_seen", ok, 1'b1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int t0, ni, nd, ic0, dc0;
  bit who, ok;
  logic [31:0] w;

  initial begin
    @(negedge clk);
    @(negedge clk);
    do_reset();
    mem_auto = 1'b1;
    @(negedge clk);

    // Tie straight after reset: I first, then D two cycles after I's ready.
    push(1'b0, 1'b0, 28'h0000020, '0, {4{32'h11111111}});
    push(1'b1, 1'b0, 28'h0000030, '0, {4{32'h22222222}});
    i_addr = 28'h0000020; d_addr = 28'h0000030;
    i_read = 1'b1; d_read = 1'b1;
    wait_rdy(1'b0); i_read = 1'b0;
    wait_rdy(1'b1); d_read = 1'b0;
    chk("tie_second_strobe_gap", last_gap, 2);

    // Lone I fill.
    @(negedge clk);
    ic0 = i_cnt; dc0 = d_cnt;
    push(1'b0, 1'b0, 28'h0000010, '0, {16{8'hA5}});
    i_addr = 28'h0000010; i_read = 1'b1; t0 = cyc;
    wait_rdy(1'b0); i_read = 1'b0;
    chk("ifill_strobe_latency", rise_cyc - t0, 1);
    chk("ifill_ready_latency", rdy_cyc - rise_cyc, LAT + 1);
    repeat (2) @(negedge clk);
    chk("ifill_rdata_hold", i_rdata, {16{8'hA5}});
    chk("ifill_ready_low", i_ready, 1'b0);
    chk("ifill_addr_hold", mem_addr, 28'h0000010);
    chk("ifill_i_count", i_cnt - ic0, 1);
    chk("ifill_d_count", d_cnt - dc0, 0);

    // Round robin with both requests held for six transactions.
    do_reset();
    @(negedge clk);
    ic0 = i_cnt; dc0 = d_cnt;
    for (int k = 0; k < 6; k++) begin
      w = 32'hC0DE0000 + 32'(k);
      push(k[0], 1'b0, k[0] ? 28'h0000200 : 28'h0000100, '0, {4{w}});
    end
    i_addr = 28'h0000100; d_addr = 28'h0000200;
    i_read = 1'b1; d_read = 1'b1; ni = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      wait_any(who, ok);
      if (!ok) break;
      if (who) begin nd++; if (nd == 3) d_read = 1'b0; end
      else     begin ni++; if (ni == 3) i_read = 1'b0; end
    end
    i_read = 1'b0; d_read = 1'b0;
    chk("rr_i_count", i_cnt - ic0, 3);
    chk("rr_d_count", d_cnt - dc0, 3);

    // Write-back then fill from D.
    @(negedge clk);
    dc0 = d_cnt;
    push(1'b1, 1'b1, 28'h0ABCDEF, {8{16'h1234}}, '0);
    d_addr = 28'h0ABCDEF; d_wdata = {8{16'h1234}}; d_write = 1'b1;
    wait_rdy(1'b1); d_write = 1'b0;
    push(1'b1, 1'b0, 28'h0ABCDF0, '0, {4{32'hDEADBEEF}});
    d_addr = 28'h0ABCDF0; d_read = 1'b1;
    wait_rdy(1'b1); d_read = 1'b0;
    chk("wbfill_d_count", d_cnt - dc0, 2);

    // Illegal read+write from D: the write must win.
    @(negedge clk);
    push(1'b1, 1'b1, 28'h0000444, {4{32'h5A5A5A5A}}, '0);
    d_addr = 28'h0000444; d_wdata = {4{32'h5A5A5A5A}};
    d_read = 1'b1; d_write = 1'b1;
    wait_rdy(1'b1); d_read = 1'b0; d_write = 1'b0;

    // Reset while D is busy, then I must win the post-reset tie.
    @(negedge clk);
    mem_auto = 1'b0;
    push(1'b1, 1'b0, 28'h0000040, '0, '0);
    d_addr = 28'h0000040; d_read = 1'b1;
    for (int k = 0; k < 10 && !mem_read; k++) @(negedge clk);
    chk("midop_busy", mem_read, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_mem_read", mem_read, 1'b0);
    chk("midop_mem_addr", mem_addr, '0);
    chk("midop_d_rdata", d_rdata, '0);
    chk("midop_i_rdata", i_rdata, '0);
    exp_q.delete();
    push(1'b0, 1'b0, 28'h0000050, '0, {4{32'h0F0F0F0F}});
    push(1'b1, 1'b0, 28'h0000040, '0, {4{32'hF0F0F0F0}});
    i_addr = 28'h0000050; i_read = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; mem_auto = 1'b1;
    wait_rdy(1'b0); i_read = 1'b0;
    wait_rdy(1'b1); d_read = 1'b0;

    // Stray mem_ready while idle: no pulse out, arbiter stays idle.
    @(negedge clk);
    mem_auto = 1'b0;
    ic0 = i_cnt; dc0 = d_cnt;
    spur_cnt++;
    repeat (4) @(negedge clk);
    chk("spur_i_count", i_cnt - ic0, 0);
    chk("spur_d_count", d_cnt - dc0, 0);
    chk("spur_mem_read", mem_read, 1'b0);
    chk("spur_i_rdata_kept", i_rdata, {4{32'h0F0F0F0F}});
    mem_auto = 1'b1;
    push(1'b0, 1'b0, 28'h0000060, '0, {4{32'h76543210}});
    i_addr = 28'h0000060; i_read = 1'b1; t0 = cyc;
    wait_rdy(1'b0); i_read = 1'b0;
    chk("spur_idle_strobe_latency", rise_cyc - t0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
